// File: rtl/serial_bypass_add_ctrl_if.sv
// Operand/result bundle for the serial bypass adder.
// master drives start and the operands; slave is the adder.
interface serial_bypass_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic [7:0]       cycles;

  // Handshake: an addition is accepted on the rising edge where start=1 and ready=1.
  // A/B/cin are only sampled on that edge. done is a one-cycle pulse, and S/Cout/cycles
  // hold from that cycle until the next done.
  modport master (
    output start, A, B, cin,
    input  ready, done, S, Cout, cycles
  );

  modport slave (
    input  start, A, B, cin,
    output ready, done, S, Cout, cycles
  );
endinterface

// File: rtl/serial_bypass_add_ctrl.sv
// Bit-serial adder with a single full adder, skipping whole BLK-bit blocks whose
// propagate bits are all set (their sum is ~carry and the carry passes through).
module serial_bypass_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_bypass_add_ctrl_if.slave  bus,
  output logic [1:0]               state
);
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] BLK_I   = IDX_W'(BLK);
  localparam logic [IDX_W-1:0] WIDTH_I = IDX_W'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [WIDTH-1:0] a_sh, b_sh, sum;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [7:0]       run_cnt;

  logic [WIDTH-1:0] a_nxt, b_nxt, sum_nxt;
  logic             carry_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             bypass, fa_s, fa_c, last;

  assign bypass = ((idx % BLK_I) == '0) && (&(a_sh[BLK-1:0] ^ b_sh[BLK-1:0]));
  assign fa_s   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c   = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (carry & a_sh[0]);

  // Operands shift right and the sum fills from the MSB, so after WIDTH bits the
  // sum register is aligned without any indexed writes.
  always_comb begin
    a_nxt     = a_sh;
    b_nxt     = b_sh;
    sum_nxt   = sum;
    carry_nxt = carry;
    idx_nxt   = idx;
    if (bypass) begin
      a_nxt                  = a_sh >> BLK;
      b_nxt                  = b_sh >> BLK;
      sum_nxt                = sum >> BLK;
      sum_nxt[WIDTH-1 -: BLK] = {BLK{~carry}};
      idx_nxt                = idx + BLK_I;
    end else begin
      a_nxt          = a_sh >> 1;
      b_nxt          = b_sh >> 1;
      sum_nxt        = sum >> 1;
      sum_nxt[WIDTH-1] = fa_s;
      carry_nxt      = fa_c;
      idx_nxt        = idx + 1'b1;
    end
  end

  assign last = (idx_nxt == WIDTH_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      sum        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      run_cnt    <= '0;
      bus.S      <= '0;
      bus.Cout   <= 1'b0;
      bus.cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.A;
            b_sh    <= bus.B;
            carry   <= bus.cin;
            idx     <= '0;
            sum     <= '0;
            run_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_nxt;
          b_sh    <= b_nxt;
          sum     <= sum_nxt;
          carry   <= carry_nxt;
          idx     <= idx_nxt;
          run_cnt <= run_cnt + 8'd1;
          // Results are loaded on entry to DONE so they are valid while done is high.
          if (last) begin
            bus.S      <= sum_nxt;
            bus.Cout   <= carry_nxt;
            bus.cycles <= run_cnt + 8'd1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_serial_bypass_add_ctrl.sv
// Scoreboard bench for serial_bypass_add_ctrl: directed cases, reset abort, biased random.
module tb_serial_bypass_add_ctrl;
  localparam int W   = 16;
  localparam int BLK = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_bypass_add_ctrl_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  serial_bypass_add_ctrl #(.WIDTH(W), .BLK(BLK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];
  logic [24:0] held = '0;
  logic        prev_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // independent reference: walk the operand bits the way the spec describes
  function automatic logic [24:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] p, m;
    logic [W:0]   t;
    int i, n;
    p = a ^ b;
    m = W'((1 << BLK) - 1);
    i = 0;
    n = 0;
    while (i < W) begin
      if ((i % BLK) == 0 && ((p >> i) & m) == m) i += BLK;
      else i++;
      n++;
    end
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return {t, 8'(n)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      held      = '0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        check_val("ready_in_done", {31'd0, bus.ready}, 32'd0);
        check_val("done_consec", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check_val("done_unexp", {31'd0, bus.done}, 32'd0);
        end else begin
          held = exp_q.pop_front();
          check_val("result", {7'd0, bus.Cout, bus.S, bus.cycles}, {7'd0, held});
        end
      end else begin
        check_val("hold", {7'd0, bus.Cout, bus.S, bus.cycles}, {7'd0, held});
      end
      prev_done = bus.done;
    end
  end

  // driver: one directed addition, optionally keeping start high with fresh operands
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit hold_start, input logic [W-1:0] es,
                        input logic ec, input logic [7:0] ecyc);
    int n;
    @(negedge clk);
    check_val({name, "_ready"}, {31'd0, bus.ready}, 32'd1);
    bus.A     = a;
    bus.B     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    exp_q.push_back({ec, es, ecyc});
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (hold_start) begin
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.cin = 1'($urandom_range(1, 0));
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && n < 40);
    bus.start = 1'b0;
    check_val({name, "_latency"}, n, 32'(ecyc) + 32'd1);
    @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic c;
    int accepts, cyc, wait_n;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'd0, bus.ready}, 32'd1);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_res", {7'd0, bus.Cout, bus.S, bus.cycles}, 32'd0);
    check_val("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("zero",    16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd16);
    run_op("all_byp", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 8'd4);
    run_op("byp12",   16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 8'd10);
    run_op("hold_st", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd7);
    repeat (3) @(posedge clk);

    // reset five cycles into a 16-cycle addition
    @(negedge clk);
    bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_val("abort_ready", {31'd0, bus.ready}, 32'd1);
    check_val("abort_done", {31'd0, bus.done}, 32'd0);
    check_val("abort_res", {7'd0, bus.Cout, bus.S, bus.cycles}, 32'd0);
    check_val("abort_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 8'd16);
    repeat (2) @(posedge clk);

    // back-to-back random, biased toward propagating blocks to keep runtime short
    accepts = 0;
    cyc = 0;
    while (accepts < 10000 && cyc < 95000) begin
      @(negedge clk);
      cyc++;
      a = W'($urandom);
      b = W'($urandom);
      for (int k = 0; k < W / BLK; k++)
        if ($urandom_range(7, 0) != 0) b[k*BLK +: BLK] = ~a[k*BLK +: BLK];
      c = 1'($urandom_range(1, 0));
      bus.A     = a;
      bus.B     = b;
      bus.cin   = c;
      bus.start = 1'b1;
      if (bus.ready) begin
        exp_q.push_back(model(a, b, c));
        accepts++;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check_val("rand_ops", accepts, 32'd10000);
    check_val("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
